// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
//   Two-master to one-fabric APB arbiter. A three-state FSM (IDLE, SETUP,
//   ACCESS) forwards the granted master's request to the fabric. The grant
//   alternates when both masters are waiting. An optional wait-state timeout
//   aborts a stalled ACCESS phase with an error response.
//
// Handshake: a master holds psel and its payload stable until it sees
//   pready=1. That pready=1 cycle is its completion cycle. The fabric
//   completes an ACCESS cycle when fab_i_pready=1. Response outputs are
//   meaningful only while pready=1, and are 0 outside ACCESS.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   m0_t_* / m1_t_*            master-side APB targets
//                              (psel/penable/pwrite/paddr/pwdata/pwstrb in,
//                               pready/pslverr/prdata out)
//   fab_i_*                    fabric-side APB initiator
//                              (request out, pready/pslverr/prdata in)
//   timeout_o                  one-cycle pulse when an ACCESS phase is aborted
// -----------------------------------------------------------------------------
module apb_arbiter #(
  parameter int ADDR_W      = 34,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_t_psel,
  input  logic              m0_t_penable,
  input  logic              m0_t_pwrite,
  input  logic [ADDR_W-1:0] m0_t_paddr,
  input  logic [31:0]       m0_t_pwdata,
  input  logic [3:0]        m0_t_pwstrb,
  output logic              m0_t_pready,
  output logic              m0_t_pslverr,
  output logic [31:0]       m0_t_prdata,

  input  logic              m1_t_psel,
  input  logic              m1_t_penable,
  input  logic              m1_t_pwrite,
  input  logic [ADDR_W-1:0] m1_t_paddr,
  input  logic [31:0]       m1_t_pwdata,
  input  logic [3:0]        m1_t_pwstrb,
  output logic              m1_t_pready,
  output logic              m1_t_pslverr,
  output logic [31:0]       m1_t_prdata,

  output logic              fab_i_psel,
  output logic              fab_i_penable,
  output logic              fab_i_pwrite,
  output logic [ADDR_W-1:0] fab_i_paddr,
  output logic [31:0]       fab_i_pwdata,
  output logic [3:0]        fab_i_pwstrb,
  input  logic              fab_i_pready,
  input  logic              fab_i_pslverr,
  input  logic [31:0]       fab_i_prdata,

  output logic              timeout_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
  localparam logic       TIMEOUT_EN  = (TIMEOUT_CYC != 0);

  logic [1:0] state_q, state_d;
  logic       grant_q, grant_d;          // 0: m0 owns the fabric, 1: m1
  logic       last_grant_q, last_grant_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Arbitration looks only at psel. penable from the masters has no role.
  logic unused_penable;
  assign unused_penable = m0_t_penable ^ m1_t_penable;

  logic in_access;
  logic timeout_hit;
  logic xfer_done;
  logic other_psel;

  assign in_access   = (state_q == ST_ACCESS);
  assign timeout_hit = in_access && TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LIM)
                       && !fab_i_pready;
  assign xfer_done   = in_access && (fab_i_pready || timeout_hit);
  // The owner's own psel is deliberately not consulted on completion, so a
  // waiting master always gets the next slot.
  assign other_psel  = grant_q ? m0_t_psel : m1_t_psel;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_t_psel || m1_t_psel) begin
          state_d = ST_SETUP;
          if (m0_t_psel && m1_t_psel) grant_d = ~last_grant_q;
          else                        grant_d = m1_t_psel;
        end
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        wait_cnt_d = 8'd0;
      end
      ST_ACCESS: begin
        if (xfer_done) begin
          last_grant_d = grant_q;
          if (other_psel) begin
            grant_d = ~grant_q;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // m0 wins the first tie after reset
      wait_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Outputs are qualified with rst_n so nothing leaks while reset is held,
  // including the cycle in which reset arrives mid-transfer.
  logic active;
  assign active = rst_n && (state_q != ST_IDLE);

  assign fab_i_psel    = active;
  assign fab_i_penable = rst_n && in_access;
  assign fab_i_pwrite  = active && (grant_q ? m1_t_pwrite : m0_t_pwrite);
  assign fab_i_paddr   = active ? (grant_q ? m1_t_paddr  : m0_t_paddr)  : '0;
  assign fab_i_pwdata  = active ? (grant_q ? m1_t_pwdata : m0_t_pwdata) : '0;
  assign fab_i_pwstrb  = active ? (grant_q ? m1_t_pwstrb : m0_t_pwstrb) : '0;

  // A timeout turns the cycle into an error completion with no read data.
  logic        rsp_valid;
  logic        rsp_pready;
  logic        rsp_pslverr;
  logic [31:0] rsp_prdata;

  assign rsp_valid   = rst_n && in_access;
  assign rsp_pready  = fab_i_pready  || timeout_hit;
  assign rsp_pslverr = fab_i_pslverr || timeout_hit;
  assign rsp_prdata  = timeout_hit ? 32'h0 : fab_i_prdata;

  assign m0_t_pready  = rsp_valid && !grant_q && rsp_pready;
  assign m0_t_pslverr = rsp_valid && !grant_q && rsp_pslverr;
  assign m0_t_prdata  = (rsp_valid && !grant_q) ? rsp_prdata : 32'h0;

  assign m1_t_pready  = rsp_valid && grant_q && rsp_pready;
  assign m1_t_pslverr = rsp_valid && grant_q && rsp_pslverr;
  assign m1_t_prdata  = (rsp_valid && grant_q) ? rsp_prdata : 32'h0;

  assign timeout_o = rst_n && timeout_hit;

endmodule

// File: tb/tb_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter
//   Directed scenarios followed by a randomized phase. In the randomized
//   phase, two APB masters issue transactions. A behavioural target inserts
//   random wait states, and some of those stalls are long enough to trigger
//   the timeout. A transfer-level model predicts which master is served next
//   and what each master must observe. An expected queue holds the response
//   promised to each transfer.
// -----------------------------------------------------------------------------
module tb_apb_arbiter;
  localparam int ADDR_W = 34;
  localparam int TO     = 4;

  logic              clk;
  logic              rst_n;
  logic              m0_t_psel, m0_t_penable, m0_t_pwrite;
  logic [ADDR_W-1:0] m0_t_paddr;
  logic [31:0]       m0_t_pwdata;
  logic [3:0]        m0_t_pwstrb;
  logic              m0_t_pready, m0_t_pslverr;
  logic [31:0]       m0_t_prdata;
  logic              m1_t_psel, m1_t_penable, m1_t_pwrite;
  logic [ADDR_W-1:0] m1_t_paddr;
  logic [31:0]       m1_t_pwdata;
  logic [3:0]        m1_t_pwstrb;
  logic              m1_t_pready, m1_t_pslverr;
  logic [31:0]       m1_t_prdata;
  logic              fab_i_psel, fab_i_penable, fab_i_pwrite;
  logic [ADDR_W-1:0] fab_i_paddr;
  logic [31:0]       fab_i_pwdata;
  logic [3:0]        fab_i_pwstrb;
  logic              fab_i_pready, fab_i_pslverr;
  logic [31:0]       fab_i_prdata;
  logic              timeout_o;

  apb_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_t_psel(m0_t_psel), .m0_t_penable(m0_t_penable), .m0_t_pwrite(m0_t_pwrite),
    .m0_t_paddr(m0_t_paddr), .m0_t_pwdata(m0_t_pwdata), .m0_t_pwstrb(m0_t_pwstrb),
    .m0_t_pready(m0_t_pready), .m0_t_pslverr(m0_t_pslverr), .m0_t_prdata(m0_t_prdata),
    .m1_t_psel(m1_t_psel), .m1_t_penable(m1_t_penable), .m1_t_pwrite(m1_t_pwrite),
    .m1_t_paddr(m1_t_paddr), .m1_t_pwdata(m1_t_pwdata), .m1_t_pwstrb(m1_t_pwstrb),
    .m1_t_pready(m1_t_pready), .m1_t_pslverr(m1_t_pslverr), .m1_t_prdata(m1_t_prdata),
    .fab_i_psel(fab_i_psel), .fab_i_penable(fab_i_penable), .fab_i_pwrite(fab_i_pwrite),
    .fab_i_paddr(fab_i_paddr), .fab_i_pwdata(fab_i_pwdata), .fab_i_pwstrb(fab_i_pwstrb),
    .fab_i_pready(fab_i_pready), .fab_i_pslverr(fab_i_pslverr), .fab_i_prdata(fab_i_prdata),
    .timeout_o(timeout_o)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [32:0] exp_q[$];   // {pslverr, prdata} promised to each transfer

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m(input int m, input logic sel, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic en);
    if (m == 0) begin
      m0_t_psel = sel; m0_t_pwrite = wr; m0_t_paddr = a;
      m0_t_pwdata = d; m0_t_pwstrb = s; m0_t_penable = en;
    end else begin
      m1_t_psel = sel; m1_t_pwrite = wr; m1_t_paddr = a;
      m1_t_pwdata = d; m1_t_pwstrb = s; m1_t_penable = en;
    end
  endtask

  task automatic idle_all();
    drive_m(0, 0, 0, '0, 32'h0, 4'h0, 0);
    drive_m(1, 0, 0, '0, 32'h0, 4'h0, 0);
    fab_i_pready = 0; fab_i_pslverr = 0; fab_i_prdata = 32'h0;
  endtask

  function automatic logic [33:0] rsp(input int m);
    return (m == 0) ? {m0_t_pready, m0_t_pslverr, m0_t_prdata}
                    : {m1_t_pready, m1_t_pslverr, m1_t_prdata};
  endfunction

  task automatic chk_fab(input string tag, input logic sel, input logic en,
                         input logic [ADDR_W-1:0] a, input logic wr,
                         input logic [31:0] d, input logic [3:0] s);
    chk({tag, "_psel"},    fab_i_psel,    sel);
    chk({tag, "_penable"}, fab_i_penable, en);
    chk({tag, "_paddr"},   fab_i_paddr,   a);
    chk({tag, "_pwrite"},  fab_i_pwrite,  wr);
    chk({tag, "_pwdata"},  fab_i_pwdata,  d);
    chk({tag, "_pwstrb"},  fab_i_pwstrb,  s);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_all();
    tick();
    tick();
    rst_n = 1;
  endtask

  // ---------------- stimulus + model ----------------
  logic [ADDR_W-1:0] a0, a1;
  logic [ADDR_W-1:0] addr [2];
  logic [31:0]       wd [2];
  logic [3:0]        st [2];
  logic              wr [2];
  logic              busy [2];
  logic [1:0]        prev_req, req_now;
  logic              g, last_served, in_xfer, start_pending, complete, is_to;
  int                xcyc, plan_waits, n_done, c0, c1, n_to;
  logic [31:0]       plan_rdata;
  logic              plan_err;
  logic [33:0]       exp_rsp, rw;
  logic [32:0]       exp_word;

  initial begin
    a0 = 34'h2_1234_5678;
    a1 = 34'h1_ABCD_EF00;

    // Reset: requests held during reset must not reach the fabric
    rst_n = 0;
    idle_all();
    m0_t_psel = 1; m1_t_psel = 1;
    tick(); tick(); settle();
    chk("rst_fab_psel", fab_i_psel, 0);
    chk("rst_fab_penable", fab_i_penable, 0);
    chk("rst_fab_paddr", fab_i_paddr, 0);
    chk("rst_m0_rsp", rsp(0), 0);
    chk("rst_m1_rsp", rsp(1), 0);
    chk("rst_timeout", timeout_o, 0);
    idle_all();
    rst_n = 1;

    // Single m0 read, zero-wait target, 3-cycle latency
    tick();
    drive_m(0, 1, 0, a0, 32'h0, 4'h0, 0);
    settle();
    chk("r029_T_psel", fab_i_psel, 0);
    tick(); settle();
    chk_fab("r029_setup", 1, 0, a0, 0, 32'h0, 4'h0);
    chk("r029_setup_m0", rsp(0), 0);
    tick();
    fab_i_pready = 1; fab_i_prdata = 32'hDEADBEEF;
    settle();
    chk_fab("r029_access", 1, 1, a0, 0, 32'h0, 4'h0);
    chk("r029_m0_rsp", rsp(0), {2'b10, 32'hDEADBEEF});
    chk("r029_m1_rsp", rsp(1), 0);
    tick(); idle_all(); settle();
    chk("r029_idle_psel", fab_i_psel, 0);

    // Tie after reset: m0 first, then m1 with no idle cycle between
    do_reset();
    tick();
    drive_m(0, 1, 0, a0, 32'h0, 4'h0, 0);
    drive_m(1, 1, 1, a1, 32'h1357_9BDF, 4'hF, 0);
    tick(); settle();
    chk_fab("r030_setup_m0", 1, 0, a0, 0, 32'h0, 4'h0);
    tick();
    fab_i_pready = 1; fab_i_prdata = 32'h1111_2222;
    settle();
    chk("r030_m0_done", rsp(0), {2'b10, 32'h1111_2222});
    chk("r030_m1_wait", rsp(1), 0);
    tick();
    drive_m(0, 0, 0, '0, 32'h0, 4'h0, 0);
    fab_i_pready = 0;
    settle();
    chk_fab("r030_setup_m1", 1, 0, a1, 1, 32'h1357_9BDF, 4'hF);
    tick();
    fab_i_pready = 1;
    settle();
    chk("r030_m1_done", rsp(1), {2'b10, 32'h1111_2222});
    chk("r030_m0_quiet", rsp(0), 0);
    tick(); idle_all(); settle();
    chk("r030_idle_psel", fab_i_psel, 0);

    // Continuous contention: grants alternate, 4 each over 8 transfers
    do_reset();
    tick();
    drive_m(0, 1, 0, a0, 32'h0, 4'h0, 0);
    drive_m(1, 1, 0, a1, 32'h0, 4'h0, 0);
    fab_i_pready = 1; fab_i_prdata = 32'h0000_0031;
    n_done = 0; c0 = 0; c1 = 0;
    for (int cy = 0; cy < 60 && n_done < 8; cy++) begin
      tick(); settle();
      if (m0_t_pready || m1_t_pready) begin
        chk("r031_single_ready", m0_t_pready && m1_t_pready, 0);
        chk("r031_grant_order", m1_t_pready, n_done % 2);
        if (m1_t_pready) c1++; else c0++;
        n_done++;
      end
    end
    chk("r031_done", n_done, 8);
    chk("r031_m0_count", c0, 4);
    chk("r031_m1_count", c1, 4);

    // Timeout with TIMEOUT_CYC=4: abort on the 5th ACCESS cycle
    do_reset();
    tick();
    drive_m(1, 1, 0, a1, 32'h0, 4'h0, 0);
    fab_i_prdata = 32'hA5A5_A5A5;
    tick(); settle();
    chk_fab("r032_setup", 1, 0, a1, 0, 32'h0, 4'h0);
    n_to = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(); settle();
      n_to += int'(timeout_o);
      chk("r032_penable", fab_i_penable, 1);
      chk("r032_m1_rsp", rsp(1), (k == 5) ? {2'b11, 32'h0} : {2'b00, 32'hA5A5_A5A5});
      chk("r032_m0_rsp", rsp(0), 0);
    end
    tick();
    drive_m(1, 0, 0, '0, 32'h0, 4'h0, 0);
    settle();
    n_to += int'(timeout_o);
    chk("r032_psel_after", fab_i_psel, 0);
    chk("r032_pulses", n_to, 1);

    // m1 write with 2 wait states and a slave error
    idle_all();
    tick();
    drive_m(1, 1, 1, a1, 32'hCAFE_F00D, 4'h5, 0);
    tick(); settle();
    chk_fab("r033_setup", 1, 0, a1, 1, 32'hCAFE_F00D, 4'h5);
    for (int k = 1; k <= 3; k++) begin
      tick();
      fab_i_pready = (k == 3); fab_i_pslverr = (k == 3);
      settle();
      chk_fab("r033_access", 1, 1, a1, 1, 32'hCAFE_F00D, 4'h5);
      chk("r033_m1_rsp", rsp(1), (k == 3) ? {2'b11, 32'h0} : {2'b00, 32'h0});
    end
    tick(); idle_all(); settle();
    chk("r033_idle_psel", fab_i_psel, 0);

    // Reset during ACCESS: transfer abandoned, next tie goes to m0
    tick();
    drive_m(0, 1, 0, a0, 32'h0, 4'h0, 0);
    tick(); tick();
    fab_i_pready = 1;
    settle();
    chk("r034_pre_m0_done", m0_t_pready, 1);
    tick(); idle_all();
    drive_m(1, 1, 0, a1, 32'h0, 4'h0, 0);
    tick(); tick();
    settle();
    chk("r034_in_access", fab_i_penable, 1);
    rst_n = 0;
    drive_m(0, 1, 0, a0, 32'h0, 4'h0, 0);
    tick();
    rst_n = 1;
    settle();
    chk_fab("r034_after_rst", 0, 0, '0, 0, 32'h0, 4'h0);
    chk("r034_m0_rsp", rsp(0), 0);
    chk("r034_m1_rsp", rsp(1), 0);
    tick(); settle();
    chk_fab("r034_tie_m0", 1, 0, a0, 0, 32'h0, 4'h0);

    // Randomized traffic against the transfer-level model
    do_reset();
    last_served = 1; in_xfer = 0; start_pending = 0; prev_req = 2'b00;
    busy[0] = 0; busy[1] = 0; g = 0; xcyc = 0;
    plan_waits = 0; plan_rdata = 32'h0; plan_err = 0;
    for (int m = 0; m < 2; m++) begin
      addr[m] = '0; wd[m] = 32'h0; st[m] = 4'h0; wr[m] = 0;
    end
    for (int cy = 0; cy < 1500; cy++) begin
      tick();
      if (start_pending) begin
        // Both waiting: the one not served last; else the only requester
        g = (prev_req == 2'b11) ? !last_served : prev_req[1];
        in_xfer = 1; xcyc = 0;
        plan_waits = $urandom_range(0, 5);
        plan_rdata = $urandom;
        plan_err   = 1'($urandom_range(0, 1));
        exp_q.push_back((plan_waits >= TO) ? {1'b1, 32'h0} : {plan_err, plan_rdata});
      end
      for (int m = 0; m < 2; m++) begin
        if (!busy[m] && cy < 1450 && $urandom_range(0, 2) != 0) begin
          busy[m] = 1;
          addr[m] = ADDR_W'({$urandom, $urandom});
          wd[m]   = $urandom;
          st[m]   = 4'($urandom_range(0, 15));
          wr[m]   = 1'($urandom_range(0, 1));
        end
        drive_m(m, busy[m], wr[m], addr[m], wd[m], st[m], 1'($urandom_range(0, 1)));
      end
      complete = in_xfer && xcyc > 0 &&
                 ((plan_waits < TO) ? (xcyc == plan_waits + 1) : (xcyc == TO + 1));
      is_to = complete && (plan_waits >= TO);
      fab_i_pready  = in_xfer && xcyc > 0 && plan_waits < TO && xcyc == plan_waits + 1;
      fab_i_pslverr = complete ? plan_err : 1'($urandom_range(0, 1));
      fab_i_prdata  = complete ? plan_rdata : $urandom;
      settle();

      chk("rnd_psel", fab_i_psel, in_xfer);
      chk("rnd_penable", fab_i_penable, in_xfer && xcyc > 0);
      chk("rnd_paddr", fab_i_paddr, in_xfer ? addr[g] : '0);
      chk("rnd_pwrite", fab_i_pwrite, in_xfer ? wr[g] : 1'b0);
      chk("rnd_pwdata", fab_i_pwdata, in_xfer ? wd[g] : 32'h0);
      chk("rnd_pwstrb", fab_i_pwstrb, in_xfer ? st[g] : 4'h0);
      chk("rnd_timeout", timeout_o, is_to);
      for (int m = 0; m < 2; m++) begin
        if (in_xfer && xcyc > 0 && m == int'(g))
          exp_rsp = is_to ? {2'b11, 32'h0} : {fab_i_pready, fab_i_pslverr, fab_i_prdata};
        else
          exp_rsp = '0;
        chk((m == 0) ? "rnd_m0_rsp" : "rnd_m1_rsp", rsp(m), exp_rsp);
      end

      req_now = {m1_t_psel, m0_t_psel};
      if (complete) begin
        rw = rsp(int'(g));
        exp_word = exp_q.pop_front();
        chk("rnd_sb_rsp", rw[32:0], exp_word);
        last_served = g;
        busy[g] = 0;
        req_now[g] = 1'b0;
        in_xfer = 0;
      end
      start_pending = !in_xfer && (req_now != 2'b00);
      prev_req = req_now;
      if (in_xfer) xcyc++;
    end
    chk("rnd_sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
